alu_arbiter: RTL and testbench

// Shares one combinational ALU between two requesters (e.g. main datapath and address/branch unit).

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_arbiter_alu.sv | 32 +++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, default width,
// slot state encoding and the opcode legality screen.
package alu_pkg;

    localparam int SIZE = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // True only for the opcodes the ALU implements.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by both requesters. Unknown opcodes
// produce a zero result; the arbiter screens them before they get here.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int SIZE = alu_pkg::SIZE
) (
    input  logic [SIZE-1:0] rd1,
    input  logic [SIZE-1:0] rd2,
    input  logic [3:0]      op,
    output logic [SIZE-1:0] rez,
    output logic            zero
);

    // Decode the opcode and compute the result; SLT is inverted and NOR is a
    // logical (single-bit) NOR, both returned zero-extended.
    always_comb begin
        rez = '0;
        case (op)
            OP_AND: rez = rd1 & rd2;
            OP_OR:  rez = rd1 | rd2;
            OP_ADD: rez = rd1 + rd2;
            OP_SUB: rez = rd1 - rd2;
            OP_SLT: rez = (rd1 < rd2) ? '0 : SIZE'(1);
            OP_NOR: rez = ((rd1 | rd2) == '0) ? SIZE'(1) : '0;
            default: rez = '0;
        endcase
    end

    assign zero = (rez == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a single registered response slot that supports full throughput.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int SIZE = alu_pkg::SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic [3:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    input  logic [3:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [SIZE-1:0] rsp_rez,
    output logic            rsp_zero,
    output logic            rsp_err
);

    slot_state_t     state;
    slot_state_t     state_next;
    logic            rr_ptr;
    logic            grant;
    logic            any_valid;
    logic            can_accept;
    logic            accept;
    logic            op_legal;
    logic [SIZE-1:0] alu_a;
    logic [SIZE-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [3:0]      sel_op;
    logic [SIZE-1:0] alu_rez;
    logic            alu_zero;

    assign rsp_valid  = (state == SLOT_FULL);
    assign can_accept = !reset && ((state == SLOT_EMPTY) || (rsp_valid && rsp_ready));
    assign any_valid  = req0_valid || req1_valid;

    // Pick the winner: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant = rr_ptr;
        end
    end

    assign req0_ready = can_accept && any_valid && (grant == 1'b0);
    assign req1_ready = can_accept && any_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    // Route the winner's operands to the ALU; idle or illegal cycles feed
    // zeros / AND so the ALU never sees stale or unsupported inputs.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = OP_AND;
        sel_op   = OP_AND;
        op_legal = 1'b1;
        if (accept) begin
            sel_op   = grant ? req1_op : req0_op;
            op_legal = op_is_legal(sel_op);
            if (op_legal) begin
                alu_a  = grant ? req1_a : req0_a;
                alu_b  = grant ? req1_b : req0_b;
                alu_op = sel_op;
            end
        end
    end

    alu_arbiter_alu #(
        .SIZE (SIZE)
    ) u_alu (
        .rd1  (alu_a),
        .rd2  (alu_b),
        .op   (alu_op),
        .rez  (alu_rez),
        .zero (alu_zero)
    );

    // Slot occupancy: fill on accept, empty on drain without a refill.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready && !accept) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    // Slot register and round-robin pointer; contents only change on accept,
    // which keeps them frozen while the consumer is stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SLOT_EMPTY;
            rr_ptr   <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_rez  <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                rr_ptr <= ~grant;
                rsp_id <= grant;
                if (op_legal) begin
                    rsp_rez  <= alu_rez;
                    rsp_zero <= alu_zero;
                    rsp_err  <= 1'b0;
                end else begin
                    rsp_rez  <= '0;
                    rsp_zero <= 1'b0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset behaviour, round-robin alternation,
// backpressure freeze, opcode results, illegal-op screening, mid-op reset.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_rez;

    int checks;
    int failures;

    alu_arbiter #(.SIZE(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_rez    (rsp_rez),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Drive one cycle's inputs on the falling edge.
    task automatic applyStimulus(input logic rst,
                                 input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                                 input logic rdy);
        @(negedge clk);
        reset      = rst;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = rdy;
        #1;
    endtask

    task automatic checkReady(input string tag, input logic r0, input logic r1);
        checkOutput({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, r0});
        checkOutput({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic id,
                            input logic [31:0] rez, input logic z, input logic e);
        @(posedge clk);
        #1;
        checkOutput({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
        checkOutput({tag, ".id"},    {31'd0, rsp_id},    {31'd0, id});
        checkOutput({tag, ".rez"},   rsp_rez,            rez);
        checkOutput({tag, ".zero"},  {31'd0, rsp_zero},  {31'd0, z});
        checkOutput({tag, ".err"},   {31'd0, rsp_err},   {31'd0, e});
    endtask

    // Stop a runaway simulation with a failure line and the summary.
    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = OP_AND;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_AND;
        rsp_ready = 1'b1;

        // Reset held with req0 valid: never ready, slot cleared.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 32'd5, 32'd7, OP_ADD, 0, 0, 0, OP_AND, 1);
            checkReady("rst", 0, 0);
            checkRsp("rst", 0, 0, 32'd0, 0, 0);
        end

        // ADD 5+7 from req0.
        applyStimulus(0, 1, 32'd5, 32'd7, OP_ADD, 0, 0, 0, OP_AND, 1);
        checkReady("add", 1, 0);
        checkRsp("add", 1, 0, 32'd12, 0, 0);

        // SUB 3-3 from req1 while draining the previous result.
        applyStimulus(0, 0, 0, 0, OP_AND, 1, 32'd3, 32'd3, OP_SUB, 1);
        checkReady("sub33", 0, 1);
        checkRsp("sub33", 1, 1, 32'd0, 1, 0);

        // Both valid every cycle: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'd0, 32'd1, OP_SUB, 1, 32'd2, 32'd9, OP_SLT, 1);
            if (i % 2 == 0) begin
                checkReady("rr0", 1, 0);
                checkRsp("rr0", 1, 0, 32'hFFFF_FFFF, 0, 0);
            end else begin
                checkReady("rr1", 0, 1);
                checkRsp("rr1", 1, 1, 32'd0, 1, 0);
            end
        end

        // SLT 9,2 -> 1.
        applyStimulus(0, 1, 32'd9, 32'd2, OP_SLT, 0, 0, 0, OP_AND, 1);
        checkReady("slt92", 1, 0);
        checkRsp("slt92", 1, 0, 32'd1, 0, 0);

        // Consumer stalls three cycles: nothing accepted, response frozen.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'd0, 32'd0, OP_NOR, 1, 32'd1, 32'd2, OP_OR, 0);
            checkReady("stall", 0, 0);
            checkRsp("stall", 1, 0, 32'd1, 0, 0);
        end

        // Stall released: drain and accept together; rr_ptr favours req1.
        applyStimulus(0, 1, 32'd0, 32'd0, OP_NOR, 1, 32'd1, 32'd2, OP_OR, 1);
        checkReady("drain", 0, 1);
        checkRsp("drain", 1, 1, 32'd3, 0, 0);

        // Illegal opcode 1010.
        applyStimulus(0, 1, 32'd5, 32'd5, 4'b1010, 0, 0, 0, OP_AND, 1);
        checkReady("ill", 1, 0);
        checkRsp("ill", 1, 0, 32'd0, 0, 1);

        // NOR 0,0 afterwards clears the error flag.
        applyStimulus(0, 1, 32'd0, 32'd0, OP_NOR, 0, 0, 0, OP_AND, 1);
        checkReady("nor", 1, 0);
        checkRsp("nor", 1, 0, 32'd1, 0, 0);

        // Slot full and stalled, then reset: response discarded.
        applyStimulus(0, 0, 0, 0, OP_AND, 0, 0, 0, OP_AND, 0);
        checkReady("hold", 0, 0);
        checkRsp("hold", 1, 0, 32'd1, 0, 0);
        applyStimulus(1, 0, 0, 0, OP_AND, 1, 32'd4, 32'd4, OP_ADD, 0);
        checkReady("midrst", 0, 0);
        checkRsp("midrst", 0, 0, 32'd0, 0, 0);

        // After reset with no requests: no spurious response appears.
        applyStimulus(0, 0, 0, 0, OP_AND, 0, 0, 0, OP_AND, 0);
        checkReady("idle", 0, 0);
        checkRsp("idle", 0, 0, 32'd0, 0, 0);

        // Pointer was reset: a tie goes to req0 (AND ff & 0f).
        applyStimulus(0, 1, 32'hFF, 32'h0F, OP_AND, 1, 32'd1, 32'd1, OP_ADD, 0);
        checkReady("tie", 1, 0);
        checkRsp("tie", 1, 0, 32'h0F, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
